// File: rtl/axi_slave_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_slave_mem_arbiter_if
// Groups the AXI slave back-end beat signals and the single-port memory
// signals handled by axi_slave_mem_arbiter.
//   slave modport  : arbiter side (takes beats, drives the memory port)
//   master modport : environment side (issues beats, models the memory)
// Signals:
//   write_valid/w_opt_addr/write_data/write_strb : write beat
//   read_req/r_opt_addr                          : read beat request
//   read_data/read_valid                         : read response
//   aw_ar_ready                                  : new AW/AR may be accepted
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   : memory port
//   err_overflow/err_range                       : sticky error flags
// ---------------------------------------------------------------------------
interface axi_slave_mem_arbiter_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH = 8
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    logic                      write_valid;
    logic [AXI_ADDR_WIDTH-1:0] w_opt_addr;
    logic [AXI_DATA_WIDTH-1:0] write_data;
    logic [STRB_W-1:0]         write_strb;
    logic                      read_req;
    logic [AXI_ADDR_WIDTH-1:0] r_opt_addr;
    logic [AXI_DATA_WIDTH-1:0] read_data;
    logic                      read_valid;
    logic                      aw_ar_ready;
    logic                      mem_en;
    logic [STRB_W-1:0]         mem_we;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [AXI_DATA_WIDTH-1:0] mem_wdata;
    logic [AXI_DATA_WIDTH-1:0] mem_rdata;
    logic                      err_overflow;
    logic                      err_range;

    modport slave (
        input  write_valid, w_opt_addr, write_data, write_strb,
        input  read_req, r_opt_addr, mem_rdata,
        output read_data, read_valid, aw_ar_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output err_overflow, err_range
    );

    modport master (
        output write_valid, w_opt_addr, write_data, write_strb,
        output read_req, r_opt_addr, mem_rdata,
        input  read_data, read_valid, aw_ar_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  err_overflow, err_range
    );
endinterface

// File: rtl/axi_slave_mem_arbiter.sv
// ---------------------------------------------------------------------------
// axi_slave_mem_arbiter
// Sequences a single-port word memory behind the AXI slave back-end.
// Write beats are buffered in a small FIFO, one read is held in a slot, and
// the memory port is round-robined between them. A read waits while any
// buffered write targets the same word so read-after-write order holds.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : axi_slave_mem_arbiter_if.slave (beats, memory port, error flags)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | arbitrating; may grant one write or one read per cycle
// RD_WAIT | read issued, counting down memory latency
// RD_RESP | read_valid pulse, read slot released on exit
// ---------------------------------------------------------------------------
module axi_slave_mem_arbiter #(
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_DATA_WIDTH   = 32,
    parameter int ADDR_LSB         = $clog2(AXI_DATA_WIDTH / 8),
    parameter int ADDR_BASE_OFFSET = 0,
    parameter int MEM_DEPTH        = 256,
    parameter int MEM_ADDR_WIDTH   = $clog2(MEM_DEPTH),
    parameter int MEM_READ_LATENCY = 1,
    parameter int WR_FIFO_DEPTH    = 4
) (
    input logic                    clk,
    input logic                    rst,
    axi_slave_mem_arbiter_if.slave bus
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(WR_FIFO_DEPTH);
    localparam int LAT_W  = $clog2(MEM_READ_LATENCY + 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] BASE_W  = AXI_ADDR_WIDTH'(ADDR_BASE_OFFSET);
    localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_W = AXI_ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [PTR_W:0]            FULL_C  = (PTR_W + 1)'(WR_FIFO_DEPTH);
    localparam logic [PTR_W:0]            READY_C = (PTR_W + 1)'(WR_FIFO_DEPTH - 2);
    localparam logic [LAT_W-1:0]          LAT_C   = LAT_W'(MEM_READ_LATENCY);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP} state_t;

    state_t state_q, state_d;

    // Range check is done on the full-width index, before truncation.
    logic [AXI_ADDR_WIDTH-1:0] w_full_idx, r_full_idx;
    logic                      w_oor, r_oor;
    assign w_full_idx = (bus.w_opt_addr - BASE_W) >> ADDR_LSB;
    assign r_full_idx = (bus.r_opt_addr - BASE_W) >> ADDR_LSB;
    assign w_oor      = (w_full_idx >= DEPTH_W);
    assign r_oor      = (r_full_idx >= DEPTH_W);

    logic [MEM_ADDR_WIDTH-1:0] fifo_idx_q  [WR_FIFO_DEPTH];
    logic                      fifo_oor_q  [WR_FIFO_DEPTH];
    logic [AXI_DATA_WIDTH-1:0] fifo_data_q [WR_FIFO_DEPTH];
    logic [STRB_W-1:0]         fifo_strb_q [WR_FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]            count_q;

    logic                      slot_full_q, slot_oor_q;
    logic [MEM_ADDR_WIDTH-1:0] slot_idx_q;

    logic                      last_grant_w_q;
    logic [LAT_W-1:0]          lat_cnt_q;
    logic [AXI_DATA_WIDTH-1:0] read_data_q;
    logic                      mem_en_q;
    logic [STRB_W-1:0]         mem_we_q;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
    logic [AXI_DATA_WIDTH-1:0] mem_wdata_q;
    logic                      err_overflow_q, err_range_q;

    logic fifo_empty, fifo_full, push, pop;
    logic raw_hazard, cand_w, cand_r, grant_w, grant_r;
    logic [PTR_W-1:0] offs;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_C);
    assign pop        = grant_w;
    // A full FIFO still accepts a beat when its head leaves in the same cycle.
    assign push       = bus.write_valid && (!fifo_full || pop);

    // Entry i is live when its distance from the head is below count.
    always_comb begin
        raw_hazard = 1'b0;
        offs       = '0;
        for (int i = 0; i < WR_FIFO_DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, offs} < count_q) && (fifo_idx_q[i] == slot_idx_q))
                raw_hazard = 1'b1;
        end
    end

    assign cand_w = !fifo_empty;
    assign cand_r = slot_full_q && !raw_hazard;

    always_comb begin
        state_d = state_q;
        grant_w = 1'b0;
        grant_r = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cand_w && cand_r) begin
                    grant_r = last_grant_w_q;
                    grant_w = !last_grant_w_q;
                end else begin
                    grant_w = cand_w;
                    grant_r = cand_r;
                end
                if (grant_r) state_d = RD_WAIT;
            end
            RD_WAIT: if (lat_cnt_q == '0) state_d = RD_RESP;
            RD_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx_q[wr_ptr_q]  <= w_full_idx[MEM_ADDR_WIDTH-1:0];
            fifo_oor_q[wr_ptr_q]  <= w_oor;
            fifo_data_q[wr_ptr_q] <= bus.write_data;
            fifo_strb_q[wr_ptr_q] <= bus.write_strb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            slot_full_q    <= 1'b0;
            slot_oor_q     <= 1'b0;
            slot_idx_q     <= '0;
            last_grant_w_q <= 1'b0;
            lat_cnt_q      <= '0;
            read_data_q    <= '0;
            mem_en_q       <= 1'b0;
            mem_we_q       <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            err_overflow_q <= 1'b0;
            err_range_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_en_q <= 1'b0;
            mem_we_q <= '0;

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
            if (bus.write_valid && !push) err_overflow_q <= 1'b1;

            if (grant_w) begin
                last_grant_w_q <= 1'b1;
                if (fifo_oor_q[rd_ptr_q]) begin
                    err_range_q <= 1'b1;
                end else begin
                    mem_en_q    <= 1'b1;
                    mem_we_q    <= fifo_strb_q[rd_ptr_q];
                    mem_addr_q  <= fifo_idx_q[rd_ptr_q];
                    mem_wdata_q <= fifo_data_q[rd_ptr_q];
                end
            end

            if (grant_r) begin
                last_grant_w_q <= 1'b0;
                lat_cnt_q      <= LAT_C;
                if (slot_oor_q) begin
                    err_range_q <= 1'b1;
                end else begin
                    mem_en_q   <= 1'b1;
                    mem_addr_q <= slot_idx_q;
                end
            end

            if (state_q == RD_WAIT) begin
                if (lat_cnt_q != '0) lat_cnt_q <= lat_cnt_q - 1'b1;
                else read_data_q <= slot_oor_q ? '0 : bus.mem_rdata;
            end

            // A request arriving while the slot is still held (RD_RESP
            // included) is dropped; the release below still takes effect.
            if (state_q == RD_RESP) slot_full_q <= 1'b0;
            if (bus.read_req) begin
                if (slot_full_q) begin
                    err_overflow_q <= 1'b1;
                end else begin
                    slot_full_q <= 1'b1;
                    slot_oor_q  <= r_oor;
                    slot_idx_q  <= r_full_idx[MEM_ADDR_WIDTH-1:0];
                end
            end
        end
    end

    assign bus.read_data    = read_data_q;
    assign bus.read_valid   = (state_q == RD_RESP);
    assign bus.aw_ar_ready  = (state_q == IDLE) && !slot_full_q && (count_q <= READY_C);
    assign bus.mem_en       = mem_en_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.err_overflow = err_overflow_q;
    assign bus.err_range    = err_range_q;
endmodule

// File: tb/tb_axi_slave_mem_arbiter.sv
module tb_axi_slave_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_slave_mem_arbiter_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .MEM_ADDR_WIDTH(8)) bus ();

    axi_slave_mem_arbiter #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .ADDR_BASE_OFFSET(0),
        .MEM_DEPTH(256), .MEM_READ_LATENCY(1), .WR_FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory with one cycle read latency
    logic [31:0] tbmem [256];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_we[b]) tbmem[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
            end else begin
                bus.mem_rdata <= tbmem[bus.mem_addr];
            end
        end
    end

    int errors = 0;
    int checks = 0;

    typedef struct {int cyc; logic [3:0] we; logic [7:0] addr; logic [31:0] wdata;} memop_t;
    typedef struct {int cyc; logic [31:0] data;} rresp_t;
    memop_t exp_mem[$];
    rresp_t exp_rd[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        memop_t e;
        rresp_t r;
        if (bus.mem_en === 1'b1) begin
            if (exp_mem.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_mem_en at cycle %0d: addr %h we %h", cyc, bus.mem_addr, bus.mem_we);
            end else begin
                e = exp_mem.pop_front();
                chk("mem_cycle", cyc, e.cyc);
                chk("mem_we", 32'(bus.mem_we), 32'(e.we));
                chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                if (e.we != 4'h0) chk("mem_wdata", bus.mem_wdata, e.wdata);
            end
        end
        if (bus.read_valid === 1'b1) begin
            if (exp_rd.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read_valid at cycle %0d: data %h", cyc, bus.read_data);
            end else begin
                r = exp_rd.pop_front();
                chk("rd_cycle", cyc, r.cyc);
                chk("read_data", bus.read_data, r.data);
            end
        end
    end

    task automatic go(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic look(int c);
        go(c);
        #3;
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        bus.write_valid = 1'b1; bus.w_opt_addr = a; bus.write_data = d; bus.write_strb = 4'hF;
    endtask

    task automatic rd(logic [31:0] a);
        bus.read_req = 1'b1; bus.r_opt_addr = a;
    endtask

    task automatic quiet();
        bus.write_valid = 1'b0; bus.read_req = 1'b0;
    endtask

    task automatic exp_w(int c, logic [7:0] a, logic [31:0] d);
        exp_mem.push_back('{c, 4'hF, a, d});
    endtask

    task automatic exp_r(int c, logic [7:0] a);
        exp_mem.push_back('{c, 4'h0, a, 32'h0});
    endtask

    task automatic exp_d(int c, logic [31:0] d);
        exp_rd.push_back('{c, d});
    endtask

    task automatic drain(string name, int limit);
        while ((exp_mem.size() != 0 || exp_rd.size() != 0) && cyc < limit) go(cyc + 1);
        checks++;
        if (exp_mem.size() != 0 || exp_rd.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d mem and %0d read events outstanding, expected 0",
                     name, exp_mem.size(), exp_rd.size());
            exp_mem.delete();
            exp_rd.delete();
        end
        go(cyc + 3);
    endtask

    task automatic do_reset();
        int c;
        c = cyc;
        quiet();
        rst = 1'b1;
        go(c + 2);
        rst = 1'b0;
    endtask

    int t;

    initial begin
        for (int i = 0; i < 256; i++) tbmem[i] = 32'h0;
        tbmem[4]   = 32'h12345678;
        tbmem[32]  = 32'hCAFEF00D;
        tbmem[128] = 32'h0BADBEEF;
        bus.write_valid = 1'b0; bus.w_opt_addr = '0; bus.write_data = '0; bus.write_strb = '0;
        bus.read_req = 1'b0; bus.r_opt_addr = '0;

        // reset values
        go(3);
        rst = 1'b0;
        look(3);
        chk("rst_read_valid", 32'(bus.read_valid), 32'h0);
        chk("rst_read_data", bus.read_data, 32'h0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_err_overflow", 32'(bus.err_overflow), 32'h0);
        chk("rst_err_range", 32'(bus.err_range), 32'h0);
        chk("rst_aw_ar_ready", 32'(bus.aw_ar_ready), 32'h1);

        // single read
        t = cyc + 1;
        exp_r(t + 2, 8'd4);
        exp_d(t + 4, 32'h12345678);
        go(t); rd(32'h10);
        go(t + 1); quiet();
        drain("single_read", t + 20);

        // single write
        t = cyc + 1;
        exp_w(t + 2, 8'd4, 32'hA5A5A5A5);
        go(t); wr(32'h10, 32'hA5A5A5A5);
        go(t + 1); quiet();
        drain("single_write", t + 20);

        // read-after-write hazard with last_grant = write
        do_reset();
        t = cyc + 1;
        exp_w(t + 2, 8'd12, 32'h7);
        exp_w(t + 3, 8'd8, 32'h1);
        exp_r(t + 4, 8'd8);
        exp_d(t + 6, 32'h1);
        go(t); wr(32'h30, 32'h7);
        go(t + 1); wr(32'h20, 32'h1); rd(32'h20);
        go(t + 2); quiet();
        drain("raw", t + 30);

        // round robin W,R,W,W
        do_reset();
        t = cyc + 1;
        exp_w(t + 2, 8'd16, 32'h11111111);
        exp_r(t + 3, 8'd32);
        exp_w(t + 7, 8'd17, 32'h22222222);
        exp_w(t + 8, 8'd18, 32'h33333333);
        exp_d(t + 5, 32'hCAFEF00D);
        go(t); wr(32'h40, 32'h11111111); rd(32'h80);
        go(t + 1); quiet(); wr(32'h44, 32'h22222222);
        go(t + 2); wr(32'h48, 32'h33333333);
        go(t + 3); quiet();
        look(t + 3);
        chk("rr_ready_busy", 32'(bus.aw_ar_ready), 32'h0);
        look(t + 9);
        chk("rr_ready_drained", 32'(bus.aw_ar_ready), 32'h1);
        drain("round_robin", t + 30);

        // write overflow while a read is in flight
        do_reset();
        t = cyc + 1;
        exp_w(t + 2, 8'd64, 32'h100);
        exp_r(t + 3, 8'd128);
        exp_d(t + 5, 32'h0BADBEEF);
        exp_w(t + 7, 8'd65, 32'h200);
        exp_w(t + 8, 8'd66, 32'h300);
        exp_w(t + 9, 8'd67, 32'h400);
        exp_w(t + 10, 8'd68, 32'h500);
        go(t); wr(32'h100, 32'h100);
        go(t + 1); wr(32'h104, 32'h200); rd(32'h200);
        go(t + 2); quiet(); wr(32'h108, 32'h300);
        go(t + 3); wr(32'h10C, 32'h400);
        go(t + 4); wr(32'h110, 32'h500);
        go(t + 5); wr(32'h114, 32'h600);
        look(t + 5);
        chk("ovf_not_yet", 32'(bus.err_overflow), 32'h0);
        go(t + 6); quiet();
        look(t + 6);
        chk("ovf_set", 32'(bus.err_overflow), 32'h1);
        chk("ovf_ready_full", 32'(bus.aw_ar_ready), 32'h0);
        look(t + 7);
        chk("ovf_ready_cnt3", 32'(bus.aw_ar_ready), 32'h0);
        look(t + 8);
        chk("ovf_ready_cnt2", 32'(bus.aw_ar_ready), 32'h1);
        drain("overflow", t + 30);

        // second read while slot full is dropped
        do_reset();
        t = cyc + 1;
        exp_r(t + 2, 8'd4);
        exp_d(t + 4, 32'hA5A5A5A5);
        go(t); rd(32'h10);
        go(t + 1); rd(32'h14);
        look(t + 1);
        chk("rd_drop_before", 32'(bus.err_overflow), 32'h0);
        go(t + 2); quiet();
        look(t + 2);
        chk("rd_drop_err", 32'(bus.err_overflow), 32'h1);
        drain("read_drop", t + 20);

        // out-of-range read between two normal reads
        do_reset();
        t = cyc + 1;
        exp_r(t + 2, 8'd32);
        exp_d(t + 4, 32'hCAFEF00D);
        exp_d(t + 9, 32'h0);
        exp_r(t + 12, 8'd32);
        exp_d(t + 14, 32'hCAFEF00D);
        go(t); rd(32'h80);
        go(t + 1); quiet();
        go(t + 5); rd(32'h400);
        go(t + 6); quiet();
        look(t + 6);
        chk("range_before", 32'(bus.err_range), 32'h0);
        look(t + 7);
        chk("range_read_set", 32'(bus.err_range), 32'h1);
        go(t + 10); rd(32'h80);
        go(t + 11); quiet();
        drain("range_read", t + 30);

        // reset during RD_WAIT
        t = cyc + 1;
        exp_r(t + 2, 8'd4);
        go(t); rd(32'h10);
        go(t + 1); quiet();
        go(t + 3); rst = 1'b1;
        look(t + 4);
        chk("rstmid_mem_en", 32'(bus.mem_en), 32'h0);
        chk("rstmid_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rstmid_read_valid", 32'(bus.read_valid), 32'h0);
        chk("rstmid_read_data", bus.read_data, 32'h0);
        chk("rstmid_err_range", 32'(bus.err_range), 32'h0);
        go(t + 5); rst = 1'b0;
        drain("reset_mid_read", t + 20);

        // out-of-range write
        t = cyc + 1;
        go(t); wr(32'h800, 32'hFFFF);
        go(t + 1); quiet();
        look(t + 1);
        chk("range_wr_before", 32'(bus.err_range), 32'h0);
        look(t + 2);
        chk("range_wr_set", 32'(bus.err_range), 32'h1);
        drain("range_write", t + 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule

// File: doc/axi_slave_mem_arbiter.md
Name: axi_slave_mem_arbiter

Overview:
Sequences the single-port word memory behind the AXI slave's simplified back-end (write_valid/w_opt_addr/write_data/write_strb, read_req/r_opt_addr, read_data/read_valid, aw_ar_ready). Buffers write beats in a small FIFO and holds one outstanding read. Round-robins the memory port between writes and reads, preserving read-after-write ordering. Translates byte addresses to word indices and generates aw_ar_ready to throttle new AW/AR acceptance.

Parameters:
AXI_ADDR_WIDTH, 32, byte-address width of w_opt_addr/r_opt_addr
AXI_DATA_WIDTH, 32, data width; strobe width = AXI_DATA_WIDTH/8
ADDR_LSB, $clog2(AXI_DATA_WIDTH/8), byte-to-word shift
ADDR_BASE_OFFSET, 0, subtracted from opt addresses before shifting
MEM_DEPTH, 256, memory words
MEM_ADDR_WIDTH, $clog2(MEM_DEPTH), memory index width
MEM_READ_LATENCY, 1, cycles from mem_en (read) to valid mem_rdata, >=1
WR_FIFO_DEPTH, 4, write-beat FIFO entries, power of 2, >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
write_valid  in  1  one-cycle write-beat pulse from slave
w_opt_addr  in  AXI_ADDR_WIDTH  write byte address
write_data  in  AXI_DATA_WIDTH  write data
write_strb  in  AXI_DATA_WIDTH/8  byte enables
read_req  in  1  one-cycle read-beat request pulse
r_opt_addr  in  AXI_ADDR_WIDTH  read byte address
read_data  out  AXI_DATA_WIDTH  registered read data
read_valid  out  1  one-cycle pulse, read_data valid
aw_ar_ready  out  1  slave may accept a new AW/AR
mem_en  out  1  memory access strobe
mem_we  out  AXI_DATA_WIDTH/8  byte write enables (0 = read)
mem_addr  out  MEM_ADDR_WIDTH  word index
mem_wdata  out  AXI_DATA_WIDTH  write data
mem_rdata  in  AXI_DATA_WIDTH  memory read data
err_overflow  out  1  sticky: write beat dropped (FIFO full) or read_req while read outstanding
err_range  out  1  sticky: access with word index >= MEM_DEPTH

Behaviour:
- Reset (rst=1 at a clk edge): FIFO empty, read slot empty, FSM=IDLE, last_grant=READ, latency counter 0; read_data=0, read_valid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, err_overflow=0, err_range=0. Reset mid-read discards it; no read_valid follows.
- Word index = (opt_addr - ADDR_BASE_OFFSET) >> ADDR_LSB, computed at AXI_ADDR_WIDTH, compared to MEM_DEPTH, then truncated to MEM_ADDR_WIDTH.
- write_valid: pushes {index, data, strb} next edge. FIFO full and no pop that cycle -> beat dropped, err_overflow set. Push+pop same cycle when full is legal.
- read_req: loads read slot if empty. Slot occupied -> request dropped, err_overflow set.
- FSM states IDLE, RD_WAIT, RD_RESP.
- IDLE, per cycle: candidates W = FIFO non-empty, R = slot full and no valid FIFO entry matches slot index (RAW hazard). W only -> grant write; R only -> grant read; both -> grant opposite of last_grant. Grant updates last_grant.
- Write grant: pop FIFO head; next cycle mem_en=1, mem_we=strb, mem_addr, mem_wdata for exactly one cycle. Stay IDLE, so writes back-to-back at one per cycle.
- Read grant: next cycle mem_en=1, mem_we=0, mem_addr=slot index; go RD_WAIT, counter=MEM_READ_LATENCY. Count down; at 0 capture mem_rdata into read_data, go RD_RESP. RD_RESP: read_valid=1 one cycle, free slot, return IDLE. Read latency from read_req = MEM_READ_LATENCY+3 cycles.
- Out-of-range write: popped, no mem_en, err_range set. Out-of-range read: no mem_en; read_data=0 and read_valid still pulse with unchanged latency; err_range set.
- No new grant in RD_WAIT/RD_RESP; pushes continue.
- aw_ar_ready = (FSM==IDLE) && read slot empty && FIFO count <= WR_FIFO_DEPTH-2 (combinational from registers).
- read_data holds its value between pulses. Sticky errors clear only on rst.

Test Plan:
- Single write: write_valid at cycle 0, addr 0x10, data 0xA5A5A5A5, strb 0xF -> cycle 2: mem_en=1, mem_we=0xF, mem_addr=4, mem_wdata=0xA5A5A5A5, single cycle.
- Single read, MEM_READ_LATENCY=1, memory word 4=0x12345678: read_req at cycle 0, addr 0x10 -> cycle 2 mem_en=1, mem_we=0, mem_addr=4; cycle 4 read_valid=1, read_data=0x12345678.
- RAW hazard: write 0x1 to addr 0x20 and read_req addr 0x20 in the same cycle, last_grant=WRITE -> write issues first; read returns 0x1.
- Round-robin: FIFO preloaded with 3 writes, read slot full to a different address -> grants alternate W,R,W,W from reset. aw_ar_ready low until drained.
- Overflow: 5 write_valid pulses on consecutive cycles while a read is in RD_WAIT (depth 4) -> 5th dropped, err_overflow=1, only 4 mem writes. Second read_req while slot full -> also dropped.
- Range/reset: read addr 0x400 with MEM_DEPTH=256 -> no mem_en, read_valid with read_data=0, err_range=1. rst asserted during RD_WAIT -> all outputs 0 next cycle, no read_valid.
